// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO between the core store path and data memory.
// Define STORE_BUF_FWD_EN to build load forwarding; otherwise loads drain the buffer first.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          ld_req,
  input  logic [31:0]   ld_adr,
  output logic          stall,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data,
  output logic [1:0]    mem_we,
  output logic [31:0]   mem_adr,
  output logic [31:0]   mem_wd,
  input  logic          mem_ready,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [1:0] TypNone = 2'b00;
  localparam logic [1:0] TypWord = 2'b01;

  logic [1:0]    typ_q  [DEPTH];
  logic [31:0]   adr_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    mem_we_q, mem_we_d;
  logic [31:0]   mem_adr_q, mem_adr_d, mem_wd_q, mem_wd_d;
  logic [1:0]    nxt_typ;
  logic [31:0]   nxt_adr, nxt_data;
  logic          is_empty, full, enq, deq, st_stall, ld_stall;

  assign is_empty = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign deq      = !is_empty && mem_ready;
  // A full buffer still accepts a store when the head leaves in the same cycle.
  assign enq      = (memwrite != TypNone) && (!full || deq);
  assign st_stall = (memwrite != TypNone) && full && !mem_ready;

  always_comb begin
    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);

    // Entry that will sit at the head after this edge; may be the incoming store.
    nxt_typ  = typ_q[head_d];
    nxt_adr  = adr_q[head_d];
    nxt_data = data_q[head_d];
    if (enq && (head_d == tail_q)) begin
      nxt_typ  = memwrite;
      nxt_adr  = dataadr;
      nxt_data = writedata;
    end

    mem_we_d  = TypNone;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    if (count_d != '0) begin
      mem_we_d  = nxt_typ;
      mem_adr_d = nxt_adr;
      mem_wd_d  = nxt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      mem_we_q  <= TypNone;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        typ_q[i]  <= TypNone;
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      if (enq) begin
        typ_q[tail_q]  <= memwrite;
        adr_q[tail_q]  <= dataadr;
        data_q[tail_q] <= writedata;
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic          hit_found;
  logic [1:0]    hit_typ;
  logic [31:0]   hit_data;
  logic [PW-1:0] idx;
  logic          unused_ld_lsb;

  assign unused_ld_lsb = ^ld_adr[1:0];

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_found = 1'b0;
    hit_typ   = TypNone;
    hit_data  = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (adr_q[idx][31:2] == ld_adr[31:2])) begin
        hit_found = 1'b1;
        hit_typ   = typ_q[idx];
        hit_data  = data_q[idx];
      end
    end
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    ld_stall = 1'b0;
    if (ld_req && hit_found) begin
      if (hit_typ == TypWord) begin
        fwd_hit  = 1'b1;
        fwd_data = hit_data;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end
`else
  logic unused_ld_adr;

  assign unused_ld_adr = ^ld_adr;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
  assign ld_stall      = ld_req && !is_empty;
`endif

  assign stall   = st_stall || ld_stall;
  assign mem_we  = mem_we_q;
  assign mem_adr = mem_adr_q;
  assign mem_wd  = mem_wd_q;
  assign empty   = is_empty;
  assign count   = count_q;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the single-cycle MIPS core and data memory. It captures each store the core issues (`memwrite`, `dataadr`, `writedata`) into a small in-order FIFO and drains one entry per accepted memory cycle. It forwards pending word stores to later loads, and stalls the core when it is full or when a load cannot be resolved. It is the stage directly downstream of the core/FPU store path, covering both integer `sw` and FPU `swc1` stores.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `CW`, $clog2(DEPTH+1): width of `count`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memwrite` in 2: store type from the core.
  - 00 = none.
  - 01 = word.
  - 10 = byte.
  - 11 = halfword.
- `dataadr` in 32: store byte address.
- `writedata` in 32: store data; byte and halfword stores use the low bits.
- `ld_req` in 1: the core is executing a load this cycle.
- `ld_adr` in 32: load byte address.
- `stall` out 1: core must hold its PC and instruction this cycle.
- `fwd_hit` out 1: `fwd_data` replaces the memory read data.
- `fwd_data` out 32: forwarded word.
- `mem_we` out 2: store type presented to memory; 00 when the buffer is empty.
- `mem_adr` out 32: head entry address.
- `mem_wd` out 32: head entry data.
- `mem_ready` in 1: memory accepts the head entry at this rising edge.
- `empty` out 1: no pending entries.
- `count` out CW: number of pending entries.

## Operation
- Storage is a circular FIFO with head pointer, tail pointer and count. Each entry holds type[1:0], adr[31:0] and data[31:0].
- Enqueue: when `memwrite != 00` and the store is accepted, write {`memwrite`, `dataadr`, `writedata`} at the tail and advance the tail.
  - A store is accepted when the buffer is not full, or it is full and `mem_ready` is high with the buffer non-empty in the same cycle.
- Dequeue: when the buffer is non-empty and `mem_ready` is high, advance the head.
- Simultaneous enqueue and dequeue leave `count` unchanged. Pointers wrap modulo DEPTH.
- `stall` for a store: asserted when `memwrite != 00`, the buffer is full and `mem_ready` is low. While stalled, the store is not enqueued and the core re-presents it.
- Load lookup (`ld_req`) compares `ld_adr[31:2]` against every valid entry; the youngest match decides the result.
  - Youngest match is a word store: `fwd_hit=1`, `fwd_data` is that entry's data, no stall.
  - Youngest match is a byte or halfword store: `stall=1` until that entry drains.
  - No match: `fwd_hit=0`, no stall.
- A store presented in the same cycle as `ld_req` is not visible to that cycle's lookup.
- `mem_we`, `mem_adr` and `mem_wd` reflect the head entry.
- When empty: `mem_we=00`, while `mem_adr` and `mem_wd` hold the last head value.

## Timing
- Reset (`reset` low), asynchronous:
  - `count=0`, `empty=1`, `mem_we=00`, `mem_adr=0`, `mem_wd=0`.
  - `stall=0`, `fwd_hit=0`, `fwd_data=0`.
  - Pointers are 0 and all entries are invalidated.
- A reset mid-drain discards all pending stores.
- Latency: a store accepted at edge N appears at the memory port after N, so `mem_we` is valid in cycle N+1. There is no empty-buffer bypass.
- `stall`, `fwd_hit` and `fwd_data` are combinational from the inputs and registered state, in the same cycle.
- `stall` has a combinational path from `mem_ready`.
- `mem_*` outputs are driven from registers only.
- Throughput: one enqueue and one dequeue per cycle. A continuous store stream with `mem_ready` held high never stalls.
- When `mem_ready` is high with the buffer empty, it is ignored.

## Configuration
- `STORE_BUF_FWD_EN` defined: load forwarding as described in Operation.
- `STORE_BUF_FWD_EN` undefined:
  - No address comparators are built; `fwd_hit=0` and `fwd_data=0` always.
  - `ld_req` asserts `stall` whenever `empty=0` (drain-before-load).

## Test plan
- Reset, then a single `sw` with `memwrite=01`, `dataadr=84`, `writedata=32'h41800888`, and `mem_ready=1`:
  - Next cycle: `mem_we=01`, `mem_adr=84`, `mem_wd=32'h41800888`.
  - One cycle later: `empty=1`.
- With `mem_ready=0`, issue 4 word stores to addresses 0, 4, 8, 12 (DEPTH=4), then a 5th to 16:
  - `count=4` and `stall=1` on the 5th store.
  - Raise `mem_ready`: the 5th store is accepted in the same cycle, `count` stays 4, and drain order is 0, 4, 8, 12, 16.
- Forwarding (FWD_EN):
  - Store word 32'hAAAA0000 to 84, then word 32'hBBBB1111 to 84, with `mem_ready=0`.
  - Then `ld_req=1`, `ld_adr=84`: `fwd_hit=1`, `fwd_data=32'hBBBB1111`, `stall=0`.
- Partial hit: store byte (`memwrite=10`) to 85, then `ld_req` to 84:
  - `stall=1` until the entry drains.
  - The next cycle after the drain: `stall=0`, `fwd_hit=0`.
- Wrap-around: 10 stores with alternating `mem_ready`; memory receives all 10 in issue order with no loss.
- Assert `reset` low mid-drain with `count=3`: `count=0`, `mem_we=00` immediately, and no further memory writes.
